// File: rtl/int2fp_pkg.sv
// Shared types, constants and the leading-one helper for the int2fp arbiter slice.
package int2fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        RESP
    } state_t;

    // Index of the most significant set bit; returns 0 for an all-zero input.
    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i[4:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/int2fp_core.sv
// Combinational signed 32-bit integer to IEEE-754 single converter.
// Truncates by default; define INT2FP_ROUND_NEAREST_EN for round-to-nearest-even.
module int2fp_core
    import int2fp_pkg::*;
(
    input  logic signed [31:0] int_i,
    output logic        [31:0] fp_o
);

    logic [31:0]      mag;
    logic [31:0]      norm;
    logic [4:0]       lead;
    logic [EXP_W-1:0] exp_b;
    logic [30:0]      body;

    always_comb begin
        // -2^31 maps to 0x80000000, which is already the correct unsigned magnitude
        mag   = int_i[31] ? (~$unsigned(int_i) + 32'd1) : $unsigned(int_i);
        lead  = lzc32(mag);
        norm  = mag << (5'd31 - lead);
        exp_b = EXP_W'(EXP_BIAS) + {3'b000, lead};
        body  = {exp_b, norm[30:30-MANT_W+1]};
`ifdef INT2FP_ROUND_NEAREST_EN
        // Carry out of the mantissa ripples straight into the exponent field
        body  = body + {30'd0, norm[7] & ((|norm[6:0]) | norm[8])};
`endif
        fp_o  = (mag == 32'd0) ? 32'd0 : {int_i[31], body};
    end

endmodule

// File: rtl/int2fp_arbiter.sv
// Two-requester arbiter sharing one int-to-float converter; result returned with requester tag.
// Optional INT2FP_ROUND_NEAREST_EN selects round-to-nearest-even inside int2fp_core.
module int2fp_arbiter
    import int2fp_pkg::*;
#(
    parameter bit RR_EN_DEFAULT = 1'b1,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    input  logic              out_ready,
    output logic              busy
);

    state_t                   state_q, state_d;
    logic                     rr_last_q, rr_last_d;
    logic signed [DATA_W-1:0] opnd_q, opnd_d;
    logic                     id_q, id_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_id_q, out_id_d;
    logic                     gnt0, gnt1;
    logic [DATA_W-1:0]        fp_res;

    int2fp_core u_core (
        .int_i (opnd_q),
        .fp_o  (fp_res)
    );

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        opnd_d     = opnd_q;
        id_d       = id_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted even though state reads IDLE
                if (!rst) begin
                    if (req0_valid && req1_valid) begin
                        if (RR_EN_DEFAULT && !rr_last_q) gnt1 = 1'b1;
                        else                             gnt0 = 1'b1;
                    end else if (req0_valid) begin
                        gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0) begin
                    opnd_d    = req0_data;
                    id_d      = 1'b0;
                    rr_last_d = 1'b0;
                    state_d   = CONV;
                end else if (gnt1) begin
                    opnd_d    = req1_data;
                    id_d      = 1'b1;
                    rr_last_d = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                out_data_d = fp_res;
                out_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            opnd_q     <= '0;
            id_q       <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            opnd_q     <= opnd_d;
            id_q       <= id_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign out_valid  = (state_q == RESP);
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_int2fp_arbiter.sv
// Directed self-checking bench for int2fp_arbiter (arbitration, conversion, backpressure, reset).
module tb_int2fp_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_id;
    logic        out_ready;
    logic        busy;

    int n_cmp;
    int n_fail;

    int2fp_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #3;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_id !== 1'b0 || busy !== 1'b0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ov=%b od=%h id=%b busy=%b r0=%b r1=%b, required all zero",
                     out_valid, out_data, out_id, busy, req0_ready, req1_ready);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_gated: r0=%b r1=%b, required 0 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: ov=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_convert();
        logic [31:0] din  [7];
        logic [31:0] dexp [7];
        logic        dsel [7];
        logic        sel;
        din  = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd16777219, 32'd12345};
`ifdef INT2FP_ROUND_NEAREST_EN
        dexp = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000, 32'h4F00_0000,
                 32'h4B80_0002, 32'h4640_E400};
`else
        dexp = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000, 32'h4EFF_FFFF,
                 32'h4B80_0001, 32'h4640_E400};
`endif
        dsel = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sel = dsel[i];
            if (sel) begin
                req1_valid = 1'b1;
                req1_data  = din[i];
            end else begin
                req0_valid = 1'b1;
                req0_data  = din[i];
            end
            #1;
            n_cmp++;
            if ((sel ? req1_ready : req0_ready) !== 1'b1 || (sel ? req0_ready : req1_ready) !== 1'b0) begin
                n_fail++;
                $display("FAIL grant[%0d]: r0=%b r1=%b, required grant to id %0d only", i, req0_ready, req1_ready, sel);
            end
            @(negedge clk);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL conv_stage[%0d]: ov=%b busy=%b, required 0 1", i, out_valid, busy);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== dexp[i] || out_id !== sel) begin
                n_fail++;
                $display("FAIL result[%0d] in=%h: ov=%b data=%h id=%b, required 1 %h %b",
                         i, din[i], out_valid, out_data, out_id, dexp[i], sel);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL back_to_idle[%0d]: ov=%b busy=%b, required 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_both_valid();
        logic        ids [2];
        logic [31:0] dat [2];
        int          got;
        logic        acc0, acc1;
        ids[0] = 1'b0; ids[1] = 1'b0; dat[0] = '0; dat[1] = '0;
        out_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'd12345;
        req1_valid = 1'b1; req1_data = 32'd100000;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL both_first_grant: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                ids[got] = out_id;
                dat[got] = out_data;
                got++;
            end
            acc0 = req0_ready;
            acc1 = req1_ready;
            @(posedge clk);
            #1;
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
        end
        n_cmp++;
        if (got !== 2) begin
            n_fail++;
            $display("FAIL both_count: results=%0d, required 2 within budget", got);
        end
        n_cmp++;
        if (ids[0] !== 1'b0 || dat[0] !== 32'h4640_E400) begin
            n_fail++;
            $display("FAIL both_first: id=%b data=%h, required 0 4640e400", ids[0], dat[0]);
        end
        n_cmp++;
        if (ids[1] !== 1'b1 || dat[1] !== 32'h47C3_5000) begin
            n_fail++;
            $display("FAIL both_second: id=%b data=%h, required 1 47c35000", ids[1], dat[1]);
        end
        // wait out the second response before re-requesting
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'd2;
        req1_valid = 1'b1; req1_data = 32'd3;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_rerequest: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] held_d;
        logic        held_id;
        int          hs;
        out_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'd1;
        req1_valid = 1'b1; req1_data = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_rr_grant: r0=%b r1=%b, required 0 1", req0_ready, req1_ready);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hBF80_0000 || out_id !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_result: ov=%b data=%h id=%b, required 1 bf800000 1", out_valid, out_data, out_id);
        end
        held_d  = out_data;
        held_id = out_id;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_id !== held_id ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: ov=%b data=%h id=%b r0=%b r1=%b, required 1 %h %b 0 0",
                         c, out_valid, out_data, out_id, req0_ready, req1_ready, held_d, held_id);
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        hs = 0;
        #1;
        if (out_valid && out_ready) hs++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) hs++;
        end
        n_cmp++;
        if (hs !== 1) begin
            n_fail++;
            $display("FAIL bp_release: handshakes=%0d, required 1", hs);
        end
    endtask

    task automatic test_reset_mid_flight();
        int stale;
        out_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'd7;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_conv: ov=%b busy=%b r0=%b, required 0 0 0", out_valid, busy, req0_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid || busy) stale++;
        end
        n_cmp++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL rst_stale: active cycles=%0d, required 0", stale);
        end
        req0_valid = 1'b1; req0_data = 32'd1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_regrant: r0=%b, required 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000 || out_id !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after_result: ov=%b data=%h id=%b, required 1 3f800000 0", out_valid, out_data, out_id);
        end
        @(negedge clk);
        out_ready  = 1'b0;
        req1_valid = 1'b1; req1_data = 32'hFFFF_FFFF;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hBF80_0000 || out_id !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_before_rst: ov=%b data=%h id=%b, required 1 bf800000 1", out_valid, out_data, out_id);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_in_resp: ov=%b busy=%b data=%h, required 0 0 00000000", out_valid, busy, out_data);
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        out_ready  = 1'b1;
        test_reset();
        test_convert();
        test_both_valid();
        test_backpressure();
        test_reset_mid_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
